hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central stall/forward scheduler for the 5-stage pipeline (F/D/E/M/W).
//  Keeps its own scoreboard of in-flight writers in E/M/W: dest reg and Tnew.
//  Compares it with the D-stage Tuse to decide stall and forwarding mux selects.
//  Also sequences the multi-cycle mult/div unit with a busy counter, and
//  freezes D-stage HI/LO users while that unit is busy.
// PARAMETERS
//  MULT_LAT  5   busy cycles loaded when a mult-class instr leaves E
//  DIV_LAT   10  busy cycles loaded when a div-class instr leaves E
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous, active-high
//  d_rs         in   5  D-stage rs address
//  d_rt         in   5  D-stage rt address
//  d_tuse_rs    in   2  Tuse of rs: 0/1/2; 3 = rs not read
//  d_tuse_rt    in   2  Tuse of rt: 0/1/2; 3 = rt not read
//  d_wa         in   5  D-stage dest reg; 0 = no write
//  d_tnew       in   2  Tnew of D instr, counted at entry to E (0..2)
//  d_md_start   in   1  D instr is mult/multu/div/divu
//  d_md_div     in   1  with d_md_start: 1 = div class
//  d_md_use     in   1  D instr touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
//  stall        out  1  freeze PC and D reg; inject bubble into E
//  e_flush      out  1  equals stall
//  fwd_d_rs     out  2  D rs mux: 0 GRF, 1 E result, 2 M result
//  fwd_d_rt     out  2  D rt mux: same encoding
//  fwd_e_rs     out  2  E rs mux: 0 carried value, 1 M result, 2 W result
//  fwd_e_rt     out  2  E rt mux: same encoding
//  md_busy      out  1  mult/div counter nonzero
// BEHAVIOUR
//  - Scoreboard regs: e_rs,e_rt,e_wa,e_tnew,e_md,e_div; m_wa,m_tnew; w_wa.
//  - Reset: every scoreboard reg = 0; md counter = 0.
//    All outputs are therefore 0 in the first cycle after reset.
//  - Per edge, no stall: E <= D fields. With stall: E <= bubble (all 0).
//  - M <= E each edge, with m_tnew = (e_tnew==0) ? 0 : e_tnew-1 (saturating).
//  - W <= M each edge; W is always Tnew 0.
//  - Match rule: addr!=0 and tuse!=3 and addr==stage wa.
//    Reg 0 never stalls and never forwards.
//  - Stall on rs: match E and e_tnew>d_tuse_rs, or match M and m_tnew>d_tuse_rs.
//    Same rule for rt.
//  - MD stall: d_md_use and (e_md or counter!=0).
//  - stall = OR of the rs, rt and MD terms; purely combinational from current state.
//  - MD counter: on an edge with e_md=1, it loads DIV_LAT if e_div else MULT_LAT.
//    Otherwise it decrements while nonzero.
//    md_busy = counter!=0. Load wins over decrement.
//  - D forwarding: select E if match E and e_tnew==0; else M if match M and m_tnew==0.
//    Otherwise 0. E has priority over M.
//  - E forwarding: select M if e_rs==m_wa, m_wa!=0 and m_tnew==0; else W if e_rs==w_wa, w_wa!=0.
//    Otherwise 0. Same for rt. M has priority over W.
//  - GRF has internal write-through, so a W-stage writer never stalls D.
//  - Reset mid-operation: scoreboard and counter clear on that edge.
//    A pending MD busy is abandoned.
// CONFIGURATION
//  HAZ_FORWARD_EN defined: forwarding exactly as above.
//  Not defined: all fwd_* outputs tied to 0.
//    Stall whenever rs or rt matches E or M, regardless of Tnew.
//    MD logic is unchanged.
// TESTING
//  1. Writer add $1 (tnew 1) in E; D beq reads $1 (tuse 0) -> stall=1 for 1 cycle.
//     Next cycle fwd_d_rs=2.
//  2. lw $2 (tnew 2) in E; D addu reads rt=$2 (tuse 1).
//     -> stall 1 cycle, then fwd_e_rt=2 once lw reaches W.
//  3. Writer $0 in E/M; D reads $0 -> stall=0, all fwd=0.
//  4. div issued; next D is mflo -> stall during e_md and 10 counted cycles.
//     md_busy falls after the 10th; stall clears the same cycle.
//  5. mult in E while D is mult -> stall; reset asserted mid-count -> md_busy=0 next cycle.
//  6. HAZ_FORWARD_EN undefined: ori $3 in M (tnew 0), D reads $3 -> stall=1, fwd_d_rs=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline stall/forward scheduler with an E/M/W writer scoreboard and mult/div busy counter.
// Optional feature: define HAZ_FORWARD_EN for Tnew-aware stalling and operand forwarding.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       e_flush,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [4:0]       e_rs_q, e_rt_q, e_wa_q, m_wa_q, w_wa_q;
  logic [4:0]       e_rs_d, e_rt_d, e_wa_d, m_wa_d, w_wa_d;
  logic [1:0]       e_tnew_q, m_tnew_q, e_tnew_d, m_tnew_d;
  logic             e_md_q, e_div_q, e_md_d, e_div_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
  logic rs_stall, rt_stall, md_stall;

  // A D-stage source hits a stage only if it is really read and is not $0.
  function automatic logic src_hit(input logic [4:0] addr, input logic [1:0] tuse,
                                   input logic [4:0] wa);
    return (addr != 5'd0) && (tuse != 2'd3) && (addr == wa);
  endfunction

  always_comb begin
    hit_e_rs = src_hit(d_rs, d_tuse_rs, e_wa_q);
    hit_e_rt = src_hit(d_rt, d_tuse_rt, e_wa_q);
    hit_m_rs = src_hit(d_rs, d_tuse_rs, m_wa_q);
    hit_m_rt = src_hit(d_rt, d_tuse_rt, m_wa_q);
  end

`ifdef HAZ_FORWARD_EN
  // Stall only when the producer cannot deliver before the consumer needs it.
  assign rs_stall = (hit_e_rs && (e_tnew_q > d_tuse_rs)) || (hit_m_rs && (m_tnew_q > d_tuse_rs));
  assign rt_stall = (hit_e_rt && (e_tnew_q > d_tuse_rt)) || (hit_m_rt && (m_tnew_q > d_tuse_rt));

  always_comb begin
    fwd_d_rs = 2'd0;
    fwd_d_rt = 2'd0;
    fwd_e_rs = 2'd0;
    fwd_e_rt = 2'd0;
    if (hit_e_rs && (e_tnew_q == 2'd0))      fwd_d_rs = 2'd1;
    else if (hit_m_rs && (m_tnew_q == 2'd0)) fwd_d_rs = 2'd2;
    if (hit_e_rt && (e_tnew_q == 2'd0))      fwd_d_rt = 2'd1;
    else if (hit_m_rt && (m_tnew_q == 2'd0)) fwd_d_rt = 2'd2;
    if ((e_rs_q == m_wa_q) && (m_wa_q != 5'd0) && (m_tnew_q == 2'd0)) fwd_e_rs = 2'd1;
    else if ((e_rs_q == w_wa_q) && (w_wa_q != 5'd0))                   fwd_e_rs = 2'd2;
    if ((e_rt_q == m_wa_q) && (m_wa_q != 5'd0) && (m_tnew_q == 2'd0)) fwd_e_rt = 2'd1;
    else if ((e_rt_q == w_wa_q) && (w_wa_q != 5'd0))                   fwd_e_rt = 2'd2;
  end
`else
  // Without bypass paths, any in-flight E/M writer of a source must drain first.
  assign rs_stall = hit_e_rs || hit_m_rs;
  assign rt_stall = hit_e_rt || hit_m_rt;
  assign fwd_d_rs = 2'd0;
  assign fwd_d_rt = 2'd0;
  assign fwd_e_rs = 2'd0;
  assign fwd_e_rt = 2'd0;

  logic unused_fwd_state;
  assign unused_fwd_state = ^{e_rs_q, e_rt_q, w_wa_q, m_tnew_q};
`endif

  assign md_stall = d_md_use && (e_md_q || (md_cnt_q != '0));
  assign stall    = rs_stall || rt_stall || md_stall;
  assign e_flush  = stall;
  assign md_busy  = (md_cnt_q != '0);

  always_comb begin
    e_rs_d   = d_rs;
    e_rt_d   = d_rt;
    e_wa_d   = d_wa;
    e_tnew_d = d_tnew;
    e_md_d   = d_md_start;
    e_div_d  = d_md_div;
    if (stall) begin
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
      e_wa_d   = 5'd0;
      e_tnew_d = 2'd0;
      e_md_d   = 1'b0;
      e_div_d  = 1'b0;
    end
    m_wa_d   = e_wa_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_wa_d   = m_wa_q;
    // A mult/div leaving E reloads the counter even if it is still running.
    md_cnt_d = md_cnt_q;
    if (e_md_q)                md_cnt_d = e_div_q ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_wa_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_wa_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_wa_q   <= 5'd0;
      md_cnt_q <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      w_wa_q   <= w_wa_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl; expectations are hand-computed per cycle
// for both the default build and the HAZ_FORWARD_EN build.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, e_flush, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .e_flush(e_flush),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .md_busy(md_busy)
  );

  // Row: inputs for one D-stage cycle plus the outputs expected in that cycle.
  // fwd_f packs {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} for the forwarding build.
  typedef struct {
    int rep; int rst;
    int rs; int tur; int rt; int tut; int wa; int tn;
    int ms; int md; int mu;
    int snf; int sf; int fwd_f; int busy;
  } vec_t;

  typedef struct {
    int cyc; int stall; int fwd; int busy;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input int rep, rst, rs, tur, rt, tut, wa, tn, ms, md, mu,
                     snf, sf, fwd_f, busy);
    vec_t v;
    v.rep = rep; v.rst = rst; v.rs = rs; v.tur = tur; v.rt = rt; v.tut = tut;
    v.wa = wa; v.tn = tn; v.ms = ms; v.md = md; v.mu = mu;
    v.snf = snf; v.sf = sf; v.fwd_f = fwd_f; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; check mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",    e.cyc, int'(stall),    e.stall);
        chk("e_flush",  e.cyc, int'(e_flush),  e.stall);
        chk("fwd_d_rs", e.cyc, int'(fwd_d_rs), (e.fwd >> 6) & 3);
        chk("fwd_d_rt", e.cyc, int'(fwd_d_rt), (e.fwd >> 4) & 3);
        chk("fwd_e_rs", e.cyc, int'(fwd_e_rs), (e.fwd >> 2) & 3);
        chk("fwd_e_rt", e.cyc, int'(fwd_e_rt), e.fwd & 3);
        chk("md_busy",  e.cyc, int'(md_busy),  e.busy);
        $display("cycle %0d: stall=%0d fwd=%0d/%0d/%0d/%0d md_busy=%0d", e.cyc, stall,
                 fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy);
      end
    end
  end

  initial begin
    int cyc = 0;
    int waited = 0;
    exp_t e;
    //  rep rst rs tur rt tut wa tn ms md mu | snf sf fwd  busy
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0); // reset state
    add(1, 0, 0, 3, 0, 3, 1, 1, 0, 0, 0,   0, 0, 8'h00, 0); // add $1, tnew 1
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 8'h00, 0); // beq $1 tuse 0
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 8'h80, 0); // add now in M
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h08, 0);
    add(1, 0, 3, 1, 0, 3, 2, 2, 0, 0, 0,   0, 0, 8'h00, 0); // lw $2, tnew 2
    add(1, 0, 0, 1, 2, 1, 4, 1, 0, 0, 0,   1, 1, 8'h00, 0); // addu reads $2 tuse 1
    add(1, 0, 0, 1, 2, 1, 4, 1, 0, 0, 0,   1, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h02, 0); // lw in W -> E rt bypass
    add(2, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 0, 2, 0, 0, 0,   0, 0, 8'h00, 0); // writers of $0
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 5, 2, 0, 0, 0,   0, 0, 8'h00, 0); // $5 writer
    add(1, 0, 5, 3, 5, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0); // $5 named but not read
    add(2, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 6, 1, 7, 1, 0, 0, 1, 1, 1,   0, 0, 8'h00, 0); // div
    add(1, 0, 0, 3, 0, 3, 8, 1, 0, 0, 1,   1, 1, 8'h00, 0); // mflo while div in E
    add(10,0, 0, 3, 0, 3, 8, 1, 0, 0, 1,   1, 1, 8'h00, 1); // 10 busy cycles
    add(1, 0, 0, 3, 0, 3, 8, 1, 0, 0, 1,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 8, 2, 0, 3, 0, 0, 0, 0, 0,   1, 0, 8'h80, 0); // $8 in M, tnew 0
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h08, 0);
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 1,   0, 0, 8'h00, 0); // mult
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 1,   1, 1, 8'h00, 0); // mult behind mult
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 1,   1, 1, 8'h00, 1);
    add(1, 1, 0, 3, 0, 3, 0, 0, 1, 0, 1,   1, 1, 8'h00, 1); // reset mid-count
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 1,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(5, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1); // MULT_LAT cycles
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 9, 2, 0, 0, 0,   0, 0, 8'h00, 0); // $9 writer
    add(1, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0,   1, 1, 8'h00, 0); // reset clears scoreboard
    add(1, 0, 9, 0, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 1, 1,   0, 0, 8'h00, 0); // div
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 1,   1, 1, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 0,   0, 0, 8'h00, 1); // mult start, no stall
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1); // load over decrement
    add(5, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1);
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 10,0, 0, 0, 0,   0, 0, 8'h00, 0); // $10 writers, tnew 0
    add(1, 0, 0, 3, 0, 3, 10,0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 10,0, 10,0, 0, 0, 0, 0, 0,   1, 0, 8'h50, 0); // E beats M
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h05, 0); // M beats W
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 3, 0, 3, 11,2, 0, 0, 0,   0, 0, 8'h00, 0); // $11 writer, tnew 2
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0);
    add(1, 0, 0, 0, 11,0, 0, 0, 0, 0, 0,   1, 1, 8'h00, 0); // M tnew 1 > tuse 0
    add(1, 0, 0, 0, 11,0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0); // W never stalls

    reset = 1'b1;
    d_rs = '0; d_rt = '0; d_wa = '0; d_tnew = '0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].rep; k++) begin
        @(posedge clk);
        #1;
        reset      = vecs[i].rst[0];
        d_rs       = 5'(vecs[i].rs);
        d_tuse_rs  = 2'(vecs[i].tur);
        d_rt       = 5'(vecs[i].rt);
        d_tuse_rt  = 2'(vecs[i].tut);
        d_wa       = 5'(vecs[i].wa);
        d_tnew     = 2'(vecs[i].tn);
        d_md_start = vecs[i].ms[0];
        d_md_div   = vecs[i].md[0];
        d_md_use   = vecs[i].mu[0];
        e.cyc  = cyc;
`ifdef HAZ_FORWARD_EN
        e.stall = vecs[i].sf;
        e.fwd   = vecs[i].fwd_f;
`else
        e.stall = vecs[i].snf;
        e.fwd   = 0;
`endif
        e.busy = vecs[i].busy;
        exp_q.push_back(e);
        cyc++;
      end
    end

    while (exp_q.size() > 0 && waited < 5) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
